// File: rtl/debug_probe_pkg.sv
// Shared types and helpers for the debug probe selector.
package debug_probe_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_FREEZE = 2'd2,
    MODE_RSVD   = 2'd3
  } probe_mode_t;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FREEZE = 2'd2
  } probe_state_t;

  // Width of a counter/index able to hold 0..value-1, never less than one bit.
  function automatic int unsigned clog2_safe(input int unsigned value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // Reserved mode encoding falls back to manual selection.
  function automatic probe_state_t decode_mode(input probe_mode_t mode);
    case (mode)
      MODE_SCAN:   return ST_SCAN;
      MODE_FREEZE: return ST_FREEZE;
      default:     return ST_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/round_robin_next.sv
// Finds the next enabled index strictly after i_current, wrapping around.
// Rotate the enable vector by current+1, then priority-encode the lowest set bit.
module round_robin_next
  import debug_probe_pkg::*;
#(
  parameter  int unsigned NUM_CHANNELS = 4,
  localparam int unsigned SEL_WIDTH    = clog2_safe(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] i_enable,
  input  logic [SEL_WIDTH-1:0]    i_current,
  output logic [SEL_WIDTH-1:0]    o_next,
  output logic                    o_found
);

  localparam int unsigned SUM_W = SEL_WIDTH + 2;
  localparam int unsigned EXT_W = 3 * NUM_CHANNELS;

  logic [EXT_W-1:0]        w_ext;
  logic [SUM_W-1:0]        w_base;
  logic [NUM_CHANNELS-1:0] w_rot;
  logic [SUM_W-1:0]        w_off;
  logic [SUM_W-1:0]        w_sum;

  // Three copies cover any shift, including out-of-range current indices.
  assign w_ext  = {3{i_enable}};
  assign w_base = SUM_W'(i_current) + SUM_W'(1);
  assign w_rot  = NUM_CHANNELS'(w_ext >> w_base);

  always_comb begin
    w_off   = '0;
    o_found = 1'b0;
    for (int o = int'(NUM_CHANNELS) - 1; o >= 0; o--) begin
      if (w_rot[o]) begin
        o_found = 1'b1;
        w_off   = SUM_W'(o);
      end
    end
  end

  // base+offset is below 3*NUM_CHANNELS, so two conditional subtracts give the modulus.
  always_comb begin
    w_sum = w_base + w_off;
    if (w_sum >= SUM_W'(NUM_CHANNELS)) w_sum = w_sum - SUM_W'(NUM_CHANNELS);
    if (w_sum >= SUM_W'(NUM_CHANNELS)) w_sum = w_sum - SUM_W'(NUM_CHANNELS);
    o_next = SEL_WIDTH'(w_sum);
  end

endmodule

// File: rtl/debug_probe_mux.sv
// Debug output selector: manual channel select, timed auto-scan and freeze,
// driving one registered value to the board display pins.
module debug_probe_mux
  import debug_probe_pkg::*;
#(
  parameter  int unsigned NUM_CHANNELS = 4,
  parameter  int unsigned DATA_WIDTH   = 8,
  parameter  int unsigned DWELL_CYCLES = 1000000,
  localparam int unsigned SEL_WIDTH    = clog2_safe(NUM_CHANNELS)
) (
  input  logic                               clock,
  input  logic                               isReset,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] channelData,
  input  logic [NUM_CHANNELS-1:0]            channelEnable,
  input  logic [SEL_WIDTH-1:0]               select,
  input  logic [1:0]                         mode,
  output logic [DATA_WIDTH-1:0]              outputValue,
  output logic [SEL_WIDTH-1:0]               activeChannel,
  output logic                               scanTick
);

  localparam int unsigned          DWELL_W    = clog2_safe(DWELL_CYCLES);
  localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  probe_state_t          r_state;
  logic [DATA_WIDTH-1:0] r_out;
  logic [SEL_WIDTH-1:0]  r_active;
  logic [DWELL_W-1:0]    r_dwell;
  logic                  r_tick;

  probe_state_t          w_state_nxt;
  logic [SEL_WIDTH-1:0]  w_active_nxt;
  logic [DWELL_W-1:0]    w_dwell_nxt;
  logic                  w_tick_nxt;
  logic                  w_hold_out;
  logic [DATA_WIDTH-1:0] w_out_nxt;
  logic [SEL_WIDTH-1:0]  w_rr_next;
  logic                  w_rr_found;
  logic                  w_cur_en;
  logic                  w_tgt_en;
  logic [DATA_WIDTH-1:0] w_tgt_data;

  round_robin_next #(
    .NUM_CHANNELS (NUM_CHANNELS)
  ) u_rr_next (
    .i_enable  (channelEnable),
    .i_current (r_active),
    .o_next    (w_rr_next),
    .o_found   (w_rr_found)
  );

  // Enable of the channel currently shown; out-of-range indices read as disabled.
  always_comb begin
    w_cur_en = 1'b0;
    for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
      if (r_active == SEL_WIDTH'(k)) w_cur_en = channelEnable[k];
    end
  end

  // Data for the channel about to be shown; never indexes channelData out of range.
  always_comb begin
    w_tgt_en   = 1'b0;
    w_tgt_data = '0;
    for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
      if (w_active_nxt == SEL_WIDTH'(k)) begin
        w_tgt_en   = channelEnable[k];
        w_tgt_data = channelData[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state follows the mode input every cycle; per-state register updates.
  always_comb begin
    w_state_nxt  = decode_mode(probe_mode_t'(mode));
    w_active_nxt = r_active;
    w_dwell_nxt  = r_dwell;
    w_tick_nxt   = 1'b0;
    w_hold_out   = 1'b0;
    case (w_state_nxt)
      ST_MANUAL: begin
        w_active_nxt = select;
        w_dwell_nxt  = '0;
      end
      ST_SCAN: begin
        if (!w_rr_found) begin
          w_active_nxt = '0;
          w_dwell_nxt  = '0;
        end else if (r_state != ST_SCAN) begin
          w_dwell_nxt  = '0;
          w_active_nxt = w_cur_en ? r_active : w_rr_next;
        end else if (r_dwell == DWELL_LAST) begin
          w_dwell_nxt  = '0;
          w_active_nxt = w_rr_next;
          w_tick_nxt   = 1'b1;
        end else begin
          w_dwell_nxt  = r_dwell + DWELL_W'(1);
        end
      end
      default: begin
        w_hold_out = 1'b1;
      end
    endcase
  end

  assign w_out_nxt = w_hold_out ? r_out : (w_tgt_en ? w_tgt_data : '0);

  always_ff @(posedge clock) begin
    if (isReset) begin
      r_state  <= ST_MANUAL;
      r_out    <= '0;
      r_active <= '0;
      r_dwell  <= '0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_out    <= w_out_nxt;
      r_active <= w_active_nxt;
      r_dwell  <= w_dwell_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign outputValue   = r_out;
  assign activeChannel = r_active;
  assign scanTick      = r_tick;

endmodule

// File: tb/tb_debug_probe_mux.sv
// Self-checking bench for debug_probe_mux (4 channels, 8 bits, dwell of 4).
module tb_debug_probe_mux;

  localparam int unsigned NCH   = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DWELL = 4;

  logic            clock;
  logic            isReset;
  logic [NCH*DW-1:0] channelData;
  logic [NCH-1:0]  channelEnable;
  logic [1:0]      select;
  logic [1:0]      mode;
  logic [DW-1:0]   outputValue;
  logic [1:0]      activeChannel;
  logic            scanTick;

  debug_probe_mux #(
    .NUM_CHANNELS (NCH),
    .DATA_WIDTH   (DW),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clock         (clock),
    .isReset       (isReset),
    .channelData   (channelData),
    .channelEnable (channelEnable),
    .select        (select),
    .mode          (mode),
    .outputValue   (outputValue),
    .activeChannel (activeChannel),
    .scanTick      (scanTick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] out;
    logic [1:0] act;
    logic       tick;
    string      name;
  } exp_t;

  typedef struct {
    logic [1:0] md;
    logic [1:0] sel;
    logic [3:0] en;
    logic [7:0] out;
    logic [1:0] act;
  } vec_t;

  int   checks;
  int   failures;
  exp_t sb_q[$];
  logic [1:0] tick_acts[$];

  // Reference model state
  int         m_st;
  logic [1:0] m_act;
  int         m_dwell;
  logic [7:0] m_out;
  logic       m_tick;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan(input logic [1:0] k);
    logic [NCH*DW-1:0] d;
    d = channelData;
    return d[k*DW +: DW];
  endfunction

  function automatic logic [1:0] next_en(input logic [1:0] cur, input logic [3:0] en);
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] c;
      c = cur + 2'(k);
      if (en[c]) return c;
    end
    return cur;
  endfunction

  task automatic model_update();
    int md;
    md = (mode == 2'd3) ? 0 : int'(mode);
    if (isReset) begin
      m_st = 0; m_act = 2'd0; m_dwell = 0; m_out = 8'h00; m_tick = 1'b0;
    end else begin
      m_tick = 1'b0;
      if (md == 0) begin
        m_act   = select;
        m_out   = channelEnable[select] ? chan(select) : 8'h00;
        m_dwell = 0;
      end else if (md == 1) begin
        if (channelEnable == 4'b0000) begin
          m_act = 2'd0; m_out = 8'h00; m_dwell = 0;
        end else begin
          if (m_st != 1) begin
            m_dwell = 0;
            if (!channelEnable[m_act]) m_act = next_en(m_act, channelEnable);
          end else if (m_dwell == int'(DWELL) - 1) begin
            m_dwell = 0;
            m_act   = next_en(m_act, channelEnable);
            m_tick  = 1'b1;
          end else begin
            m_dwell++;
          end
          m_out = channelEnable[m_act] ? chan(m_act) : 8'h00;
        end
      end
      m_st = md;
    end
  endtask

  // Push the expectation for this cycle, clock once, then pop and compare.
  task automatic cycle(input string name, input bit use_tbl, input exp_t te);
    exp_t e;
    exp_t got;
    model_update();
    if (use_tbl) e = te;
    else begin
      e.out = m_out; e.act = m_act; e.tick = m_tick;
    end
    e.name = name;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk({got.name, ".out"},  32'(outputValue),   32'(got.out));
      chk({got.name, ".act"},  32'(activeChannel), 32'(got.act));
      chk({got.name, ".tick"}, 32'(scanTick),      32'(got.tick));
    end
    if (scanTick === 1'b1) tick_acts.push_back(activeChannel);
  endtask

  task automatic run(input string name, input int n);
    exp_t none;
    none = '{out: 8'h00, act: 2'd0, tick: 1'b0, name: ""};
    for (int i = 0; i < n; i++) cycle(name, 1'b0, none);
  endtask

  task automatic chk_ticks(input string nm, input logic [1:0] exp_q[$]);
    chk({nm, ".count"}, 32'(tick_acts.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tick_acts.size(); i++)
      chk($sformatf("%s.seq%0d", nm, i), 32'(tick_acts[i]), 32'(exp_q[i]));
    tick_acts.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    exp_t te;
    logic [1:0] seq_full[$];
    logic [1:0] seq_skip[$];

    checks = 0;
    failures = 0;
    tbl[0] = '{md: 2'd0, sel: 2'd2, en: 4'b1111, out: 8'h33, act: 2'd2};
    tbl[1] = '{md: 2'd0, sel: 2'd2, en: 4'b1011, out: 8'h00, act: 2'd2};
    tbl[2] = '{md: 2'd0, sel: 2'd1, en: 4'b1011, out: 8'h22, act: 2'd1};
    tbl[3] = '{md: 2'd0, sel: 2'd3, en: 4'b1011, out: 8'h44, act: 2'd3};
    tbl[4] = '{md: 2'd3, sel: 2'd0, en: 4'b1111, out: 8'h11, act: 2'd0};
    tbl[5] = '{md: 2'd0, sel: 2'd3, en: 4'b0000, out: 8'h00, act: 2'd3};
    tbl[6] = '{md: 2'd0, sel: 2'd0, en: 4'b1111, out: 8'h11, act: 2'd0};
    seq_full = '{2'd1, 2'd2, 2'd3, 2'd0};
    seq_skip = '{2'd2, 2'd0, 2'd2, 2'd0};

    channelData   = {8'h44, 8'h33, 8'h22, 8'h11};
    channelEnable = 4'b1111;
    select        = 2'd0;
    mode          = 2'd1;
    isReset       = 1'b1;

    // Reset held two cycles while requesting SCAN
    for (int i = 0; i < 2; i++) begin
      te = '{out: 8'h00, act: 2'd0, tick: 1'b0, name: ""};
      cycle("reset", 1'b1, te);
    end
    isReset = 1'b0;

    foreach (tbl[i]) begin
      mode = tbl[i].md; select = tbl[i].sel; channelEnable = tbl[i].en;
      te = '{out: tbl[i].out, act: tbl[i].act, tick: 1'b0, name: ""};
      cycle($sformatf("manual%0d", i), 1'b1, te);
    end

    mode = 2'd1;
    tick_acts.delete();
    run("scan_full", 20);
    chk_ticks("scan_full_ticks", seq_full);

    channelEnable = 4'b0101;
    run("scan_skip", 16);
    chk_ticks("scan_skip_ticks", seq_skip);

    channelEnable = 4'b0000;
    run("scan_none", 6);
    chk("scan_none.out", 32'(outputValue), 32'h00);
    chk_ticks("scan_none_ticks", '{});

    // Freeze on channel 1 mid-dwell, change its data, then resume.
    channelEnable = 4'b1111;
    mode = 2'd0; select = 2'd1;
    run("pre_freeze", 1);
    mode = 2'd1;
    run("scan_to_dwell2", 3);
    mode = 2'd2;
    channelData[15:8] = 8'h99;
    run("freeze", 3);
    chk("freeze.held", 32'(outputValue), 32'h22);
    mode = 2'd1;
    run("resume", 1);
    chk("resume.out", 32'(outputValue), 32'h99);
    run("resume_dwell", 3);
    chk("resume_dwell.act", 32'(activeChannel), 32'd1);
    tick_acts.delete();
    run("resume_adv", 1);
    chk("resume_adv.act", 32'(activeChannel), 32'd2);
    chk("resume_adv.tick", 32'(scanTick), 32'd1);
    tick_acts.delete();

    // Live tracking: new data every cycle, including a disabled current channel.
    for (int i = 0; i < 12; i++) begin
      channelData = $urandom;
      if (i == 6) channelEnable = 4'b1010;
      run("live", 1);
    end
    channelEnable = 4'b1111;

    isReset = 1'b1;
    run("reset_midscan", 2);
    isReset = 1'b0;
    run("scan_again", 5);
    mode = 2'd2;
    run("freeze2", 2);
    isReset = 1'b1;
    te = '{out: 8'h00, act: 2'd0, tick: 1'b0, name: ""};
    cycle("reset_freeze", 1'b1, te);
    isReset = 1'b0;
    run("after_reset", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
